// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port codes, request-vector bit positions and arbiter
// state encoding.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned IDX_W     = 3;

  typedef logic [IDX_W-1:0] port_code_t;

  // Encoded port codes (index + 1); 0 means no port.
  localparam port_code_t LOCAL = 3'd1;
  localparam port_code_t NORTH = 3'd2;
  localparam port_code_t SOUTH = 3'd3;
  localparam port_code_t EAST  = 3'd4;
  localparam port_code_t WEST  = 3'd5;

  // Bit positions within a request vector.
  localparam int unsigned REQ_LOCAL = 0;
  localparam int unsigned REQ_NORTH = 1;
  localparam int unsigned REQ_SOUTH = 2;
  localparam int unsigned REQ_EAST  = 3;
  localparam int unsigned REQ_WEST  = 4;

  typedef enum logic {
    StIdle,
    StLocked
  } state_e;

endpackage

// File: rtl/output_port_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
interface output_port_arbiter_if;
  import noc_pkg::*;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] tail_in;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_code;
  logic                 busy;
  logic                 fire;

  // master: requesting side and downstream; slave: the arbiter.
  modport master (
    output req, tail_in, out_ready,
    input  grant, grant_code, busy, fire
  );

  modport slave (
    input  req, tail_in, out_ready,
    output grant, grant_code, busy, fire
  );

endinterface

// File: rtl/rr_priority_select.sv
// Cyclic priority select: first set request at or after ptr, wrapping from the top index to 0.
module rr_priority_select
  import noc_pkg::*;
#(
  parameter int unsigned NumPorts = NUM_PORTS,
  parameter int unsigned IdxW     = IDX_W
) (
  input  logic [NumPorts-1:0] req,
  input  logic [IdxW-1:0]     ptr,
  output logic                any,
  output logic [IdxW-1:0]     sel
);

  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b);
    int unsigned s;
    s = a + b;
    if (s >= NumPorts) s = s - NumPorts;
    return s;
  endfunction

  logic [NumPorts-1:0] rot;
  int unsigned         ptr_i;
  int unsigned         first;
  logic                found;

  // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    ptr_i = 32'(ptr);
    rot   = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      for (int unsigned j = 0; j < NumPorts; j++) begin
        if (j == wrap_add(i, ptr_i)) rot[i] = req[j];
      end
    end
    found = 1'b0;
    first = 0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        first = i;
      end
    end
    any = found;
    sel = IdxW'(wrap_add(first, ptr_i));
  end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output round-robin arbiter: grants one input for a whole packet (head to tail flit),
// then releases for one idle cycle and advances the priority pointer past the winner.
module output_port_arbiter
  import noc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  output_port_arbiter_if.slave  bus
);

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     code_q, code_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;

  logic             any;
  logic [IDX_W-1:0] sel;
  logic             fire;
  logic             tail_hit;

  rr_priority_select #(
    .NumPorts (NUM_PORTS),
    .IdxW     (IDX_W)
  ) u_sel (
    .req (bus.req),
    .ptr (ptr_q),
    .any (any),
    .sel (sel)
  );

  // grant_q is one-hot or zero, so masking selects only the granted input.
  assign fire     = |(grant_q & bus.req) & bus.out_ready;
  assign tail_hit = |(grant_q & bus.tail_in);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d = StLocked;
          for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            grant_d[i] = (sel == IDX_W'(i));
          end
          code_d = sel + IDX_W'(1);
        end
      end
      StLocked: begin
        if (fire && tail_hit) begin
          state_d = StIdle;
          grant_d = '0;
          code_d  = '0;
          // code_q is index + 1, which is already the next pointer except at the wrap.
          ptr_d   = (code_q == IDX_W'(NUM_PORTS)) ? '0 : code_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      code_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_code = code_q;
  assign bus.busy       = (state_q == StLocked);
  assign bus.fire       = fire;

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port round-robin arbiter in the mesh router; one instance per output direction (local, north, south, east, west).
- Each input port's route computation raises one bit of its 5-bit request vector.
- Bit k of each input's vector for this output is gathered into req[k].
- The arbiter grants the output to one input and holds the grant for the whole packet, head to tail flit, under downstream backpressure.
- It then rotates priority.

Parameters:
- NUM_PORTS, 5: number of requesting input ports. Index order: 0 local, 1 north, 2 south, 3 east, 4 west.
- IDX_W, 3: width of the encoded grant index/port code.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_PORTS  per-input request for this output; held while the input has a flit for it.
- tail_in  input  NUM_PORTS  per-input flag: the current flit at that input is the tail (a single-flit packet has head = tail).
- out_ready  input  1  downstream (next router / local sink) can accept a flit this cycle.
- grant  output  NUM_PORTS  one-hot registered grant; all zero when idle.
- grant_code  output  IDX_W  registered code of the granted input: index+1 (local=1, north=2, south=3, east=4, west=5); 0 when idle.
- busy  output  1  registered; 1 while in LOCKED.
- fire  output  1  combinational; a flit transfers this cycle: |(grant & req) & out_ready.

Behaviour:
- Reset value of every output: clk and rst as named above; reset is asynchronous and active-high. Reset gives state=IDLE, grant=0, grant_code=0, busy=0, priority pointer ptr=0. fire is 0 as a consequence.
- Reset mid-packet: the grant is dropped immediately and the packet is not resumed; the upstream is reset too.
- State IDLE:
  - If any req bit is set, select the first set bit at or after ptr, searching cyclically upward and wrapping 4->0.
  - On the next edge: grant=onehot(sel), grant_code=sel+1, busy=1, state=LOCKED.
  - Latency from request to grant is 1 cycle. No transfer occurs in IDLE.
- State LOCKED, granted index g:
  - fire = req[g] & out_ready. Requests from other inputs are ignored.
  - If fire and tail_in[g]: on the next edge grant=0, grant_code=0, busy=0, state=IDLE, ptr=(g+1) mod NUM_PORTS.
  - If fire and not tail_in[g]: stay LOCKED (body flit).
  - If req[g]=0 (upstream bubble) or out_ready=0: hold the grant, no transfer, ptr unchanged. No timeout.
- Throughput:
  - One dead IDLE cycle between packets.
  - Max one flit/cycle within a packet.
  - Single-flit packets therefore use the output at most every 2 cycles.
- ptr wrap: g=4 gives ptr=0.
- Simultaneous events:
  - A request arriving on the same cycle as a tail transfer is evaluated in the following IDLE cycle with the updated ptr.
  - A request that drops while in IDLE before the grant edge is not granted (the selection is registered).
- tail_in is sampled only for index g; tail_in bits of non-granted inputs are don't-care.
- Grant is always one-hot or zero.
- grant_code is always consistent with grant.

Decomposition:
- Shared package noc_pkg holds:
  - port codes LOCAL=3'd1, NORTH=3'd2, SOUTH=3'd3, EAST=3'd4, WEST=3'd5;
  - request-vector bit positions (0 local … 4 west);
  - NUM_PORTS;
  - state encoding IDLE/LOCKED.
- One sub-module, rr_priority_select: combinational (req, ptr) -> (any, sel index). Implemented as rotate, priority-encode, then un-rotate. Reused by the other output arbiters.

Test Plan:
- Reset, then req=5'b01000 (east), tail_in[3]=1, out_ready=1 -> cycle+1: grant=5'b01000, grant_code=4, fire=1; cycle+2: grant=0, busy=0, ptr=4.
- All req=5'b11111 held, single-flit packets, out_ready=1 -> grant order 0,1,2,3,4,0 (codes 1,2,3,4,5,1), one idle cycle between each.
- 4-flit packet on north (tail on the 4th transfer) with out_ready low on cycles 2-3 -> grant held 6 cycles, fire exactly 4 times, release after the 4th; south requesting throughout is not granted until after the release.
- ptr=4, req=5'b10001 -> west (index 4) granted first; after its tail, local (index 0) is granted.
- Assert rst mid-packet while grant=5'b00100 -> grant=0, busy=0, grant_code=0 immediately; after release, req=5'b00110 -> index 1 (north) granted (ptr=0).
- Granted input drops req for 2 cycles mid-packet -> grant held, fire=0, no re-arbitration; transfers resume when req returns.
